// File: rtl/onehot_pkg.sv
// Shared encodings for the one-hot/thermometer/one-cold decoder family.
package onehot_pkg;

  localparam logic [1:0] MODE_ONEHOT  = 2'd0;
  localparam logic [1:0] MODE_THERM   = 2'd1;
  localparam logic [1:0] MODE_ONECOLD = 2'd2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_code_gen.sv
// Combinational (index, mode) -> COUNT-bit code; out-of-range indices give all 0 (one-cold: all 1).
module onehot_code_gen
  import onehot_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned COUNT = 2 ** N
) (
  input  logic [N-1:0]     index_i,
  input  logic [1:0]       mode_i,
  output logic [COUNT-1:0] code_o
);

  logic             in_range;
  logic [COUNT-1:0] hot;
  logic [COUNT-1:0] therm;

  assign in_range = {1'b0, index_i} < (N+1)'(COUNT);

  always_comb begin
    hot   = '0;
    therm = '0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      hot[i]   = (index_i == N'(i));
      therm[i] = in_range && (index_i >= N'(i));
    end
  end

  // Reserved mode 3 falls through to one-hot.
  always_comb begin
    case (mode_i)
      MODE_THERM:   code_o = therm;
      MODE_ONECOLD: code_o = ~hot;
      default:      code_o = hot;
    endcase
  end

endmodule

// File: rtl/onehot_step_decoder.sv
// Registered, valid/ready index -> code decoder with auto up/down stepping and wrap-around.
module onehot_step_decoder
  import onehot_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned COUNT = 2 ** N
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_index_i,
  input  logic [1:0]       in_mode_i,
  input  logic             step_i,
  input  logic             step_dir_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [COUNT-1:0] out_code_o,
  output logic [N-1:0]     out_index_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [N-1:0] LastIdx = N'(COUNT - 1);
  localparam logic [N:0]   CountW  = (N+1)'(COUNT);

  state_e           state_q, state_d;
  logic [N-1:0]     index_q, index_d;
  logic [1:0]       mode_q, mode_d;
  logic [COUNT-1:0] code_q, gen_code;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             code_upd;
  logic             load;
  logic             consume;
  logic             idx_oor;

  assign in_ready_o = !rst_i && ((state_q == ST_EMPTY) || out_ready_i);
  assign load       = in_valid_i && in_ready_o;
  assign consume    = (state_q == ST_FULL) && out_ready_i;
  assign idx_oor    = {1'b0, index_q} >= CountW;

  onehot_code_gen #(
    .N     (N),
    .COUNT (COUNT)
  ) u_code_gen (
    .index_i (index_d),
    .mode_i  (mode_d),
    .code_o  (gen_code)
  );

  // Priority on consume: load > step > drain. Code only changes on load or step so it
  // keeps its last value while empty.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    code_upd = 1'b0;
    if (load) begin
      state_d  = ST_FULL;
      index_d  = in_index_i;
      mode_d   = in_mode_i;
      err_d    = {1'b0, in_index_i} >= CountW;
      code_upd = 1'b1;
    end else if (consume) begin
      if (step_i) begin
        code_upd = 1'b1;
        if (!step_dir_i) begin
          if (index_q >= LastIdx) begin
            index_d = '0;
            wrap_d  = 1'b1;
          end else begin
            index_d = index_q + N'(1);
          end
        end else if ((index_q == '0) || idx_oor) begin
          index_d = LastIdx;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q - N'(1);
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      index_q <= '0;
      mode_q  <= MODE_ONEHOT;
      code_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      if (code_upd) begin
        code_q <= gen_code;
      end
    end
  end

  assign out_valid_o = (state_q == ST_FULL);
  assign out_code_o  = code_q;
  assign out_index_o = index_q;
  assign wrap_o      = wrap_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_onehot_step_decoder.sv
// Directed bench: scoreboard of expected outputs checked on the first cycle of each output.
module tb_onehot_step_decoder;

  localparam int unsigned N     = 4;
  localparam int unsigned COUNT = 10;

  typedef struct packed {
    logic [COUNT-1:0] code;
    logic [N-1:0]     index;
    logic             wrap;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_index = '0;
  logic [1:0]       in_mode = '0;
  logic             step = 1'b0;
  logic             step_dir = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [COUNT-1:0] out_code;
  logic [N-1:0]     out_index;
  logic             wrap;
  logic             err;

  logic             b_in_valid = 1'b0;
  logic             b_in_ready;
  logic [3:0]       b_in_index = '0;
  logic [1:0]       b_in_mode = '0;
  logic             b_step = 1'b0;
  logic             b_out_valid;
  logic             b_out_ready = 1'b0;
  logic [15:0]      b_out_code;
  logic [3:0]       b_out_index;
  logic             b_wrap;
  logic             b_err;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic fresh = 1'b1;

  always #5 clk = ~clk;

  onehot_step_decoder #(
    .N     (N),
    .COUNT (COUNT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_index_i  (in_index),
    .in_mode_i   (in_mode),
    .step_i      (step),
    .step_dir_i  (step_dir),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_code_o  (out_code),
    .out_index_o (out_index),
    .wrap_o      (wrap),
    .err_o       (err)
  );

  onehot_step_decoder #(
    .N     (4),
    .COUNT (16)
  ) dut16 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_index_i  (b_in_index),
    .in_mode_i   (b_in_mode),
    .step_i      (b_step),
    .step_dir_i  (1'b0),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_code_o  (b_out_code),
    .out_index_o (b_out_index),
    .wrap_o      (b_wrap),
    .err_o       (b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int idx, input int mode, input logic st,
                       input logic dir, input logic rdy);
    in_valid  = v;
    in_index  = N'(idx);
    in_mode   = 2'(mode);
    step      = st;
    step_dir  = dir;
    out_ready = rdy;
  endtask

  task automatic push(input int code, input int idx, input logic w, input logic e);
    exp_t x;
    x.code  = COUNT'(code);
    x.index = N'(idx);
    x.wrap  = w;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // First cycle of each output is compared against the scoreboard; held cycles must not pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst || !out_valid) begin
      fresh = 1'b1;
    end else begin
      if (fresh) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_code", 32'(out_code), 32'(e.code));
          chk("out_index", 32'(out_index), 32'(e.index));
          chk("wrap", 32'(wrap), 32'(e.wrap));
          chk("err", 32'(err), 32'(e.err));
        end
      end else begin
        chk("wrap_held", 32'(wrap), 32'd0);
        chk("err_held", 32'(err), 32'd0);
      end
      fresh = out_ready;
    end
  end

  initial begin
    // Reset values
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_wrap_err", 32'({wrap, err}), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: single one-hot load, one-cycle output, code held after drain
    drive(1'b1, 3, 0, 1'b0, 1'b0, 1'b1);
    push(10'h008, 3, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("t1_drained", 32'(out_valid), 32'd0);
    chk("t1_code_hold", 32'(out_code), 32'h008);
    chk("t1_index_hold", 32'(out_index), 32'd3);

    // 2: back-to-back thermometer then one-cold
    drive(1'b1, 5, 1, 1'b0, 1'b0, 1'b1);
    push(10'h03F, 5, 1'b0, 1'b0);
    cyc();
    chk("t2_in_ready_a", 32'(in_ready), 32'd1);
    drive(1'b1, 5, 2, 1'b0, 1'b0, 1'b1);
    push(10'h3DF, 5, 1'b0, 1'b0);
    cyc();
    chk("t2_in_ready_b", 32'(in_ready), 32'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();

    // 3: backpressure with a pending load
    drive(1'b1, 2, 0, 1'b0, 1'b0, 1'b1);
    push(10'h004, 2, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      cyc();
      chk("t3_code_stable", 32'(out_code), 32'h004);
      chk("t3_valid_held", 32'(out_valid), 32'd1);
    end
    drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b1);
    push(10'h080, 7, 1'b0, 1'b0);
    #1;
    chk("t3_in_ready_rel", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();

    // 4: stepping up and down across the wrap boundary; step dropped on a load
    drive(1'b1, 9, 0, 1'b1, 1'b0, 1'b1);
    push(10'h200, 9, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    push(10'h001, 0, 1'b1, 1'b0);
    cyc();
    push(10'h002, 1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    push(10'h001, 0, 1'b0, 1'b0);
    cyc();
    push(10'h200, 9, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 4, 0, 1'b1, 1'b1, 1'b1);
    push(10'h010, 4, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();

    // 5: out-of-range loads, then stepping back into range
    drive(1'b1, 12, 0, 1'b0, 1'b0, 1'b1);
    push(10'h000, 12, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    push(10'h001, 0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 12, 2, 1'b0, 1'b0, 1'b1);
    push(10'h3FF, 12, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    push(10'h1FF, 9, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 6, 3, 1'b0, 1'b0, 1'b1);
    push(10'h040, 6, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc();

    // 6: reset while an output is stalled
    drive(1'b1, 8, 1, 1'b0, 1'b0, 1'b1);
    push(10'h1FF, 8, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_code", 32'(out_code), 32'd0);
    chk("t6_out_index", 32'(out_index), 32'd0);
    chk("t6_wrap_err", 32'({wrap, err}), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_post_valid", 32'(out_valid), 32'd0);

    // COUNT=16: full-width thermometer and natural wrap
    b_in_valid  = 1'b1;
    b_in_index  = 4'd15;
    b_in_mode   = 2'd1;
    b_out_ready = 1'b1;
    cyc();
    chk("c16_code", 32'(b_out_code), 32'hFFFF);
    chk("c16_index", 32'(b_out_index), 32'd15);
    chk("c16_valid", 32'(b_out_valid), 32'd1);
    b_in_valid = 1'b0;
    b_step     = 1'b1;
    cyc();
    chk("c16_wrap_code", 32'(b_out_code), 32'h0001);
    chk("c16_wrap", 32'(b_wrap), 32'd1);
    b_step = 1'b0;
    cyc();
    chk("c16_drained", 32'(b_out_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
